// File: rtl/mem_arbiter.sv
// Two-port arbiter onto a single memory request/return channel, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 always wins a tie.
module mem_arbiter (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ0_ADDR_VALID,
   input  logic [31:0] REQ0_ADDR,
   input  logic        REQ0_DATA_VALID,
   input  logic [31:0] REQ0_DATA,
   output logic        REQ0_READY,
   output logic        REQ0_RESP_VALID,
   output logic [31:0] REQ0_RESP_DATA,
   input  logic        REQ0_RESP_READY,
   input  logic        REQ1_ADDR_VALID,
   input  logic [31:0] REQ1_ADDR,
   input  logic        REQ1_DATA_VALID,
   input  logic [31:0] REQ1_DATA,
   output logic        REQ1_READY,
   output logic        REQ1_RESP_VALID,
   output logic [31:0] REQ1_RESP_DATA,
   input  logic        REQ1_RESP_READY,
   output logic        MEM_SEND_ADDR_VALID,
   output logic [31:0] MEM_SEND_ADDR,
   output logic        MEM_SEND_DATA_VALID,
   output logic [31:0] MEM_SEND_DATA,
   input  logic        MEM_SEND_READY,
   input  logic        MEM_RECEIVE_VALID,
   input  logic [31:0] MEM_RECEIVE_DATA,
   output logic        MEM_RECEIVE_READY
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;

   state_t      state;
   logic        owner;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic        wr_q;
   logic [31:0] resp_q;
   logic        grant;
   logic        accept;
   logic        send_act;
   logic        resp_act;
   logic        owner_resp_ready;

`ifdef MEM_ARB_RR_EN
   logic        last_grant;
`endif

   // Port selection: a lone requester always wins; a tie depends on the build.
   always_comb begin
      grant = 1'b0;
      if (REQ1_ADDR_VALID && !REQ0_ADDR_VALID) begin
         grant = 1'b1;
      end
`ifdef MEM_ARB_RR_EN
      else if (REQ1_ADDR_VALID && REQ0_ADDR_VALID) begin
         grant = ~last_grant;
      end
`endif
   end

   assign accept           = !RST && (state == IDLE) && (REQ0_ADDR_VALID || REQ1_ADDR_VALID);
   assign send_act         = !RST && (state == SEND);
   assign resp_act         = !RST && (state == RESP);
   assign owner_resp_ready = owner ? REQ1_RESP_READY : REQ0_RESP_READY;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         owner  <= 1'b0;
         addr_q <= 32'h0;
         data_q <= 32'h0;
         wr_q   <= 1'b0;
         resp_q <= 32'h0;
`ifdef MEM_ARB_RR_EN
         last_grant <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  owner  <= grant;
                  addr_q <= grant ? REQ1_ADDR : REQ0_ADDR;
                  data_q <= grant ? REQ1_DATA : REQ0_DATA;
                  wr_q   <= grant ? REQ1_DATA_VALID : REQ0_DATA_VALID;
`ifdef MEM_ARB_RR_EN
                  last_grant <= grant;
`endif
                  state  <= SEND;
               end
            end
            SEND: begin
               if (MEM_SEND_READY) state <= WAIT;
            end
            WAIT: begin
               if (MEM_RECEIVE_VALID) begin
                  resp_q <= MEM_RECEIVE_DATA;
                  state  <= RESP;
               end
            end
            RESP: begin
               if (owner_resp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode from registered state; everything is forced low while in reset.
   assign REQ0_READY          = accept && !grant;
   assign REQ1_READY          = accept && grant;
   assign MEM_SEND_ADDR_VALID = send_act;
   assign MEM_SEND_ADDR       = send_act ? addr_q : 32'h0;
   assign MEM_SEND_DATA_VALID = send_act && wr_q;
   assign MEM_SEND_DATA       = send_act ? data_q : 32'h0;
   assign MEM_RECEIVE_READY   = !RST && (state == WAIT);
   assign REQ0_RESP_VALID     = resp_act && !owner;
   assign REQ0_RESP_DATA      = (resp_act && !owner) ? resp_q : 32'h0;
   assign REQ1_RESP_VALID     = resp_act && owner;
   assign REQ1_RESP_DATA      = (resp_act && owner) ? resp_q : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus corner-case sequences.
module tb_mem_arbiter;

   typedef struct packed {
      logic        rst;
      logic        r0v;
      logic [31:0] r0a;
      logic        r0dv;
      logic [31:0] r0d;
      logic        r0rr;
      logic        r1v;
      logic [31:0] r1a;
      logic        r1dv;
      logic [31:0] r1d;
      logic        r1rr;
      logic        sr;
      logic        rv;
      logic [31:0] rd;
   } in_t;

   typedef struct packed {
      logic        r0ry;
      logic        r1ry;
      logic        sav;
      logic [31:0] sa;
      logic        sdv;
      logic [31:0] sd;
      logic        rry;
      logic        r0rv;
      logic [31:0] r0rd;
      logic        r1rv;
      logic [31:0] r1rd;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   logic        CLK;
   logic        RST;
   logic        REQ0_ADDR_VALID, REQ0_DATA_VALID, REQ0_READY, REQ0_RESP_VALID, REQ0_RESP_READY;
   logic [31:0] REQ0_ADDR, REQ0_DATA, REQ0_RESP_DATA;
   logic        REQ1_ADDR_VALID, REQ1_DATA_VALID, REQ1_READY, REQ1_RESP_VALID, REQ1_RESP_READY;
   logic [31:0] REQ1_ADDR, REQ1_DATA, REQ1_RESP_DATA;
   logic        MEM_SEND_ADDR_VALID, MEM_SEND_DATA_VALID, MEM_SEND_READY;
   logic [31:0] MEM_SEND_ADDR, MEM_SEND_DATA;
   logic        MEM_RECEIVE_VALID, MEM_RECEIVE_READY;
   logic [31:0] MEM_RECEIVE_DATA;

   int n_vec = 0;
   int n_err = 0;

   mem_arbiter dut (
      .CLK(CLK), .RST(RST),
      .REQ0_ADDR_VALID(REQ0_ADDR_VALID), .REQ0_ADDR(REQ0_ADDR),
      .REQ0_DATA_VALID(REQ0_DATA_VALID), .REQ0_DATA(REQ0_DATA),
      .REQ0_READY(REQ0_READY), .REQ0_RESP_VALID(REQ0_RESP_VALID),
      .REQ0_RESP_DATA(REQ0_RESP_DATA), .REQ0_RESP_READY(REQ0_RESP_READY),
      .REQ1_ADDR_VALID(REQ1_ADDR_VALID), .REQ1_ADDR(REQ1_ADDR),
      .REQ1_DATA_VALID(REQ1_DATA_VALID), .REQ1_DATA(REQ1_DATA),
      .REQ1_READY(REQ1_READY), .REQ1_RESP_VALID(REQ1_RESP_VALID),
      .REQ1_RESP_DATA(REQ1_RESP_DATA), .REQ1_RESP_READY(REQ1_RESP_READY),
      .MEM_SEND_ADDR_VALID(MEM_SEND_ADDR_VALID), .MEM_SEND_ADDR(MEM_SEND_ADDR),
      .MEM_SEND_DATA_VALID(MEM_SEND_DATA_VALID), .MEM_SEND_DATA(MEM_SEND_DATA),
      .MEM_SEND_READY(MEM_SEND_READY),
      .MEM_RECEIVE_VALID(MEM_RECEIVE_VALID), .MEM_RECEIVE_DATA(MEM_RECEIVE_DATA),
      .MEM_RECEIVE_READY(MEM_RECEIVE_READY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic out_t observe();
      out_t o;
      o.r0ry = REQ0_READY;
      o.r1ry = REQ1_READY;
      o.sav  = MEM_SEND_ADDR_VALID;
      o.sa   = MEM_SEND_ADDR;
      o.sdv  = MEM_SEND_DATA_VALID;
      o.sd   = MEM_SEND_DATA;
      o.rry  = MEM_RECEIVE_READY;
      o.r0rv = REQ0_RESP_VALID;
      o.r0rd = REQ0_RESP_DATA;
      o.r1rv = REQ1_RESP_VALID;
      o.r1rd = REQ1_RESP_DATA;
      return o;
   endfunction

   task automatic drive(input in_t v);
      RST = v.rst;
      REQ0_ADDR_VALID = v.r0v;  REQ0_ADDR = v.r0a;  REQ0_DATA_VALID = v.r0dv;
      REQ0_DATA = v.r0d;        REQ0_RESP_READY = v.r0rr;
      REQ1_ADDR_VALID = v.r1v;  REQ1_ADDR = v.r1a;  REQ1_DATA_VALID = v.r1dv;
      REQ1_DATA = v.r1d;        REQ1_RESP_READY = v.r1rr;
      MEM_SEND_READY = v.sr;    MEM_RECEIVE_VALID = v.rv; MEM_RECEIVE_DATA = v.rd;
   endtask

   task automatic chk(input string name, input logic [134:0] act, input logic [134:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic smp();
      @(negedge CLK);
   endtask

   task automatic nxt();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      in_t z;
      z = '0;
      z.rst = 1'b1;
      drive(z);
      nxt();
      nxt();
      RST = 1'b0;
   endtask

   vec_t vecs[$];
   vec_t v;
   in_t  zi;
   out_t o;
   int   grants[$];
   int   resps[$];
   int   exp_g[4];
   int   act_g;
   int   act_r;
   int   cyc;

   initial begin
      zi = '0;
      zi.rst = 1'b1;
      drive(zi);

      // Reset with a live request: everything must stay low.
      v = '0; v.i.rst = 1'b1; v.i.r0v = 1'b1; v.i.r0a = 32'h99; vecs.push_back(v);
      v = '0; v.i.rst = 1'b1; v.i.r1v = 1'b1; vecs.push_back(v);
      v = '0; vecs.push_back(v);
      // REQ0 read of 0x10 returning DEADBEEF, minimum latency.
      v = '0; v.i.r0v = 1'b1; v.i.r0a = 32'h10; v.o.r0ry = 1'b1; vecs.push_back(v);
      v = '0; v.i.sr = 1'b1; v.o.sav = 1'b1; v.o.sa = 32'h10; vecs.push_back(v);
      v = '0; v.i.rv = 1'b1; v.i.rd = 32'hDEAD_BEEF; v.o.rry = 1'b1; vecs.push_back(v);
      v = '0; v.i.r0rr = 1'b1; v.o.r0rv = 1'b1; v.o.r0rd = 32'hDEAD_BEEF; vecs.push_back(v);
      v = '0; vecs.push_back(v);
      // REQ1 write of 0x20, send stalled 3 cycles while REQ0 waits.
      v = '0; v.i.r1v = 1'b1; v.i.r1a = 32'h20; v.i.r1dv = 1'b1; v.i.r1d = 32'h1234_5678;
      v.o.r1ry = 1'b1; vecs.push_back(v);
      for (int k = 0; k < 4; k++) begin
         v = '0; v.i.r0v = 1'b1; v.i.r0a = 32'h77; v.i.sr = (k == 3);
         v.o.sav = 1'b1; v.o.sa = 32'h20; v.o.sdv = 1'b1; v.o.sd = 32'h1234_5678;
         vecs.push_back(v);
      end
      v = '0; v.o.rry = 1'b1; vecs.push_back(v);
      v = '0; v.i.rv = 1'b1; v.i.rd = 32'hCAFE_0001; v.o.rry = 1'b1; vecs.push_back(v);
      v = '0; v.i.r1rr = 1'b1; v.o.r1rv = 1'b1; v.o.r1rd = 32'hCAFE_0001; vecs.push_back(v);
      v = '0; v.i.r1rr = 1'b1; vecs.push_back(v);

      foreach (vecs[k]) begin
         drive(vecs[k].i);
         smp();
         chk($sformatf("vec%0d", k), observe(), vecs[k].o);
         nxt();
      end

      // Both ports held valid for four transactions.
`ifdef MEM_ARB_RR_EN
      exp_g = '{0, 1, 0, 1};
`else
      exp_g = '{0, 0, 0, 0};
`endif
      do_reset();
      REQ0_ADDR_VALID = 1'b1; REQ0_ADDR = 32'h100;
      REQ1_ADDR_VALID = 1'b1; REQ1_ADDR = 32'h200;
      MEM_SEND_READY = 1'b1;  MEM_RECEIVE_VALID = 1'b1; MEM_RECEIVE_DATA = 32'h5;
      REQ0_RESP_READY = 1'b1; REQ1_RESP_READY = 1'b1;
      cyc = 0;
      while (resps.size() < 4 && cyc < 60) begin
         smp();
         if (grants.size() < 4) begin
            if (REQ0_READY) grants.push_back(0);
            if (REQ1_READY) grants.push_back(1);
         end
         if (REQ0_RESP_VALID) resps.push_back(0);
         if (REQ1_RESP_VALID) resps.push_back(1);
         nxt();
         cyc++;
      end
      for (int k = 0; k < 4; k++) begin
         act_g = (k < grants.size()) ? grants[k] : 9;
         act_r = (k < resps.size())  ? resps[k]  : 9;
         chk($sformatf("grant%0d", k), 135'(act_g), 135'(exp_g[k]));
         chk($sformatf("resp_port%0d", k), 135'(act_r), 135'(exp_g[k]));
      end

      // Response back-pressure: valid/data held, no new accept while in RESP.
      do_reset();
      REQ0_ADDR_VALID = 1'b1; REQ0_ADDR = 32'h30;
      MEM_SEND_READY = 1'b1;  MEM_RECEIVE_VALID = 1'b1; MEM_RECEIVE_DATA = 32'h55AA_1234;
      smp();
      chk("bp_accept", 135'(REQ0_READY), 135'(1));
      nxt();
      REQ0_ADDR_VALID = 1'b0;
      REQ1_ADDR_VALID = 1'b1; REQ1_ADDR = 32'h34;
      nxt();
      nxt();
      for (int k = 0; k < 5; k++) begin
         smp();
         chk($sformatf("bp_hold%0d", k),
             {REQ0_RESP_VALID, REQ0_RESP_DATA, REQ0_READY, REQ1_READY, REQ1_RESP_VALID},
             {1'b1, 32'h55AA_1234, 1'b0, 1'b0, 1'b0});
         nxt();
      end
      REQ0_RESP_READY = 1'b1;
      smp();
      chk("bp_release", {REQ0_RESP_VALID, REQ0_RESP_DATA, REQ1_READY},
          {1'b1, 32'h55AA_1234, 1'b0});
      nxt();
      REQ0_RESP_READY = 1'b0;
      smp();
      chk("bp_next_accept", {REQ0_RESP_VALID, REQ1_READY}, {1'b0, 1'b1});
      nxt();

      // Reset during WAIT discards the transaction; the next one completes.
      do_reset();
      REQ0_ADDR_VALID = 1'b1; REQ0_ADDR = 32'h40; REQ0_DATA_VALID = 1'b1; REQ0_DATA = 32'hA5A5_A5A5;
      MEM_SEND_READY = 1'b1;
      smp();
      chk("rst_accept", 135'(REQ0_READY), 135'(1));
      nxt();
      REQ0_ADDR_VALID = 1'b0;
      smp();
      chk("rst_send", {MEM_SEND_ADDR_VALID, MEM_SEND_ADDR, MEM_SEND_DATA_VALID, MEM_SEND_DATA},
          {1'b1, 32'h40, 1'b1, 32'hA5A5_A5A5});
      nxt();
      smp();
      chk("rst_wait", 135'(MEM_RECEIVE_READY), 135'(1));
      nxt();
      RST = 1'b1; MEM_RECEIVE_VALID = 1'b1; MEM_RECEIVE_DATA = 32'hBBBB_0000;
      REQ0_RESP_READY = 1'b1; REQ1_RESP_READY = 1'b1;
      smp();
      o = '0;
      chk("rst_outputs", observe(), o);
      nxt();
      RST = 1'b0;
      for (int k = 0; k < 3; k++) begin
         smp();
         chk($sformatf("rst_quiet%0d", k), observe(), o);
         nxt();
      end
      REQ1_ADDR_VALID = 1'b1; REQ1_ADDR = 32'h44; REQ1_DATA_VALID = 1'b0;
      MEM_RECEIVE_DATA = 32'h0BAD_F00D;
      smp();
      chk("post_rst_accept", {REQ0_READY, REQ1_READY}, {1'b0, 1'b1});
      nxt();
      REQ1_ADDR_VALID = 1'b0;
      nxt();
      nxt();
      smp();
      chk("post_rst_resp", {REQ1_RESP_VALID, REQ1_RESP_DATA, REQ0_RESP_VALID},
          {1'b1, 32'h0BAD_F00D, 1'b0});
      nxt();
      smp();
      chk("post_rst_done", {REQ1_RESP_VALID, REQ0_RESP_VALID}, {1'b0, 1'b0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have no parameters; all address and data paths SHALL be 32 bits.
REQ-002 The CLK input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 The RST input, 1 bit, SHALL be the reset: synchronous, active-high.
REQ-004 The REQ0_ADDR_VALID input, 1 bit, SHALL be the request valid from requester 0.
REQ-005 The REQ0_ADDR input, 32 bits, SHALL be the request address from requester 0.
REQ-006 The REQ0_DATA_VALID input, 1 bit, SHALL be high for a write (set) and low for a read (ref).
REQ-007 The REQ0_DATA input, 32 bits, SHALL be the write data from requester 0.
REQ-008 The REQ0_READY output, 1 bit, SHALL accept the request from requester 0.
REQ-009 The REQ0_RESP_VALID output, 1 bit, SHALL be the response valid to requester 0.
REQ-010 The REQ0_RESP_DATA output, 32 bits, SHALL be the memory return word for requester 0.
REQ-011 The REQ0_RESP_READY input, 1 bit, SHALL be the response ready from requester 0.
REQ-012 The REQ1_* signals SHALL be identical to the REQ0_* signals in name suffix, direction and width, and SHALL serve requester 1.
REQ-013 The MEM_SEND_ADDR_VALID, MEM_SEND_ADDR, MEM_SEND_DATA_VALID and MEM_SEND_DATA outputs (1/32/1/32 bits) and the MEM_SEND_READY input (1 bit) SHALL form the shared memory request channel.
REQ-014 The MEM_RECEIVE_VALID and MEM_RECEIVE_DATA inputs (1/32 bits) and the MEM_RECEIVE_READY output (1 bit) SHALL form the shared memory return channel.

Function
REQ-015 The FSM SHALL have four states: IDLE, SEND, WAIT and RESP, with exactly one transaction outstanding at a time.
REQ-016 In IDLE, REQn_READY SHALL be asserted combinationally, only for the granted requester, when that requester's REQn_ADDR_VALID is 1; the other requester's REQn_READY SHALL be 0.
REQ-017 On an IDLE accept, the block SHALL latch the address, data-valid and data, record the owner, and enter SEND on the next cycle.
REQ-018 In SEND, MEM_SEND_ADDR_VALID SHALL be 1 and the MEM_SEND_* outputs SHALL present the latched values, held stable until MEM_SEND_READY is 1; the block SHALL then enter WAIT.
REQ-019 In WAIT, MEM_RECEIVE_READY SHALL be 1 and all other states SHALL drive it to 0.
REQ-020 On the WAIT handshake (MEM_RECEIVE_VALID & MEM_RECEIVE_READY), the block SHALL latch MEM_RECEIVE_DATA and enter RESP.
REQ-021 In RESP, the owner's REQn_RESP_VALID SHALL be 1, with REQn_RESP_DATA equal to the latched word, held until REQn_RESP_READY is 1; the block SHALL then return to IDLE.
REQ-022 The non-owner's REQn_RESP_VALID SHALL be 0 at all times.
REQ-023 Reads and writes SHALL both produce exactly one response.
REQ-024 The minimum latency from accept to response valid SHALL be 3 cycles, given MEM_SEND_READY=1 and MEM_RECEIVE_VALID=1 at each opportunity.
REQ-025 The block SHALL NOT assert REQn_READY outside IDLE; requests arriving while busy SHALL wait.
REQ-026 A 1-bit last-grant register SHALL update on every accept.

Reset
REQ-027 While RST=1, the FSM SHALL go to IDLE, the last-grant register to 1 (so port 0 wins the first tie), and all latched data to 0.
REQ-028 While RST=1, all VALID and READY outputs SHALL be 0, and all data outputs SHALL be 0.
REQ-029 Asserting RST mid-transaction SHALL discard the transaction without issuing a response.

Configuration
REQ-030 With MEM_ARB_RR_EN defined and both REQn_ADDR_VALID high in IDLE, the block SHALL grant the port not granted last (round-robin).
REQ-031 With MEM_ARB_RR_EN undefined, the block SHALL always grant port 0 on a tie (fixed priority); the last-grant register MAY be omitted.

Verification
REQ-032 After reset is released, a bench SHALL check REQ0_READY, REQ1_READY, MEM_SEND_ADDR_VALID, REQ0_RESP_VALID and REQ1_RESP_VALID are all 0.
REQ-033 REQ0 read of ADDR=32'h0000_0010 with memory returning 32'hDEAD_BEEF -> MEM_SEND_ADDR=32'h10 and MEM_SEND_DATA_VALID=0; REQ0_RESP_DATA=32'hDEAD_BEEF; REQ1_RESP_VALID stays 0.
REQ-034 REQ1 write of ADDR=32'h20, DATA=32'h1234_5678 with MEM_SEND_READY delayed 3 cycles -> MEM_SEND_* held stable for all 3 cycles, MEM_SEND_DATA_VALID=1, and exactly one REQ1 response.
REQ-035 Both ports held valid for 4 transactions -> grant order 0,1,0,1 with MEM_ARB_RR_EN defined, and 0,0,0,0 without it.
REQ-036 REQ0_RESP_READY held 0 for 5 cycles in RESP -> REQ0_RESP_VALID/DATA held for those 5 cycles, and no REQn_READY asserted until RESP exits.
REQ-037 RST pulsed during WAIT -> return to IDLE, no response on either port, and the next request completes normally.
